// File: rtl/fpga_spi_slave_mem.sv
// SPI mode-0 slave with byte-addressed register memory, oversampled in clk_i.
// Optional build macro FPGA_SPIS_RDID_EN enables the 0x9F read-ID command.
module fpga_spi_slave_mem #(
  parameter int DEPTH = 256
`ifdef FPGA_SPIS_RDID_EN
  , parameter logic [23:0] RDID = 24'hC2_20_17
`endif
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       spi_sck_i,
  input  logic       spi_csn_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_oe_o,
  output logic       cmd_valid_o,
  output logic [7:0] cmd_o,
  output logic       err_o
);

  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_RDATA, S_WDATA, S_IGNORE, S_RDID
  } state_t;

  state_t              r_state;
  logic [2:0]          r_sck_s;
  logic [1:0]          r_csn_s;
  logic [1:0]          r_mosi_s;
  logic [2:0]          r_bitcnt;
  logic [1:0]          r_bytecnt;
  logic [2:0]          r_fcnt;
  logic [6:0]          r_sh;
  logic [6:0]          r_tx;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wr;
  logic                r_miso;
  logic                r_oe;
  logic                r_cmd_valid;
  logic [7:0]          r_cmd;
  logic                r_err;
  logic [7:0]          r_mem [DEPTH];
`ifdef FPGA_SPIS_RDID_EN
  logic [23:0]         r_id;
`endif

  logic                w_csn;
  logic                w_mosi;
  logic                w_rise;
  logic                w_fall;
  logic                w_last_bit;
  logic [7:0]          w_byte;
  logic [7:0]          w_rbyte;
  logic                w_we;

  // Two-stage synchronisers; sck gets a third stage for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sck_s  <= '0;
      r_csn_s  <= 2'b11;
      r_mosi_s <= '0;
    end else begin
      r_sck_s  <= {r_sck_s[1:0], spi_sck_i};
      r_csn_s  <= {r_csn_s[0], spi_csn_i};
      r_mosi_s <= {r_mosi_s[0], spi_mosi_i};
    end
  end

  assign w_csn      = r_csn_s[1];
  assign w_mosi     = r_mosi_s[1];
  assign w_rise     = r_sck_s[1] & ~r_sck_s[2];
  assign w_fall     = ~r_sck_s[1] & r_sck_s[2];
  assign w_last_bit = (r_bitcnt == 3'd7);
  assign w_byte     = {r_sh, w_mosi};
  assign w_rbyte    = r_mem[r_addr];
  assign w_we       = (r_state == S_WDATA) && !w_csn && w_rise && w_last_bit;

  // Memory has no reset so it maps onto distributed RAM.
  always_ff @(posedge clk_i) begin
    if (w_we) r_mem[r_addr] <= w_byte;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_bitcnt    <= '0;
      r_bytecnt   <= '0;
      r_fcnt      <= '0;
      r_sh        <= '0;
      r_tx        <= '0;
      r_addr      <= '0;
      r_wr        <= 1'b0;
      r_miso      <= 1'b0;
      r_oe        <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd       <= '0;
      r_err       <= 1'b0;
`ifdef FPGA_SPIS_RDID_EN
      r_id        <= '0;
`endif
    end else begin
      r_cmd_valid <= 1'b0;
      if (w_csn) begin
        // Deselect wins over any edge seen in the same cycle.
        r_state   <= S_IDLE;
        r_bitcnt  <= '0;
        r_bytecnt <= '0;
        r_fcnt    <= '0;
        r_oe      <= 1'b0;
        r_miso    <= 1'b0;
      end else begin
        if (w_rise) begin
          r_sh     <= w_byte[6:0];
          r_bitcnt <= r_bitcnt + 3'd1;
        end
        case (r_state)
          S_IDLE: r_state <= S_CMD;
          S_CMD: if (w_rise && w_last_bit) begin
            r_cmd       <= w_byte;
            r_cmd_valid <= 1'b1;
            case (w_byte)
              8'h03: begin r_state <= S_ADDR; r_wr <= 1'b0; end
              8'h02: begin r_state <= S_ADDR; r_wr <= 1'b1; end
`ifdef FPGA_SPIS_RDID_EN
              8'h9F: begin r_state <= S_RDID; r_oe <= 1'b1; r_id <= RDID; end
`endif
              default: begin r_state <= S_IGNORE; r_err <= 1'b1; end
            endcase
          end
          S_ADDR: if (w_rise) begin
            r_addr <= {r_addr[ADDR_W-2:0], w_mosi};
            if (w_last_bit) begin
              r_bytecnt <= r_bytecnt + 2'd1;
              if (r_bytecnt == 2'd2) begin
                r_state <= r_wr ? S_WDATA : S_RDATA;
                r_oe    <= ~r_wr;
                r_fcnt  <= '0;
              end
            end
          end
          // First fall of each byte fetches it and advances the address.
          S_RDATA: if (w_fall) begin
            r_fcnt <= r_fcnt + 3'd1;
            if (r_fcnt == 3'd0) begin
              r_miso <= w_rbyte[7];
              r_tx   <= w_rbyte[6:0];
              r_addr <= r_addr + 1'b1;
            end else begin
              r_miso <= r_tx[6];
              r_tx   <= {r_tx[5:0], 1'b0};
            end
          end
          S_WDATA: if (w_rise && w_last_bit) r_addr <= r_addr + 1'b1;
`ifdef FPGA_SPIS_RDID_EN
          S_RDID: if (w_fall) begin
            r_miso <= r_id[23];
            r_id   <= {r_id[22:0], 1'b0};
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign spi_miso_o    = r_miso;
  assign spi_miso_oe_o = r_oe;
  assign cmd_valid_o   = r_cmd_valid;
  assign cmd_o         = r_cmd;
  assign err_o         = r_err;

endmodule

// File: tb/tb_fpga_spi_slave_mem.sv
// Scoreboard bench for fpga_spi_slave_mem: bench acts as SPI mode-0 master at 5 MHz.
module tb_fpga_spi_slave_mem;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       spi_sck_i = 1'b0;
  logic       spi_csn_i = 1'b1;
  logic       spi_mosi_i = 1'b0;
  logic       spi_miso_o;
  logic       spi_miso_oe_o;
  logic       cmd_valid_o;
  logic [7:0] cmd_o;
  logic       err_o;

  int         n_tests = 0;
  int         n_fail = 0;
  int         n_cmd_pulses = 0;
  bit         oe_seen = 1'b0;
  logic [7:0] q_rd[$];
  logic [7:0] q_cmd[$];
  logic [7:0] rd_sh = '0;
  int         rd_cnt = 0;

  fpga_spi_slave_mem dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .spi_sck_i(spi_sck_i), .spi_csn_i(spi_csn_i),
    .spi_mosi_i(spi_mosi_i), .spi_miso_o(spi_miso_o), .spi_miso_oe_o(spi_miso_oe_o),
    .cmd_valid_o(cmd_valid_o), .cmd_o(cmd_o), .err_o(err_o)
  );

  always #10 clk_i = ~clk_i;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  // Command monitor: every cmd_valid pulse is matched against the queue.
  always @(negedge clk_i) begin
    if (spi_miso_oe_o === 1'b1) oe_seen = 1'b1;
    if (cmd_valid_o === 1'b1) begin
      n_cmd_pulses++;
      if (q_cmd.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL cmd_unexpected: got %0h, required no pulse", cmd_o);
      end else begin
        check("cmd_o", {24'h0, cmd_o}, {24'h0, q_cmd.pop_front()});
      end
    end
  end

  // MISO monitor: collects bits on sck rise while the slave drives the line.
  always @(posedge spi_sck_i or posedge spi_csn_i or negedge rst_ni) begin
    if (!rst_ni || spi_csn_i) begin
      rd_cnt = 0;
    end else if (spi_miso_oe_o === 1'b1) begin
      rd_sh = {rd_sh[6:0], spi_miso_o};
      rd_cnt++;
      if (rd_cnt == 8) begin
        rd_cnt = 0;
        if (q_rd.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL miso_unexpected: got %0h, required no byte", rd_sh);
        end else begin
          check("miso_byte", {24'h0, rd_sh}, {24'h0, q_rd.pop_front()});
        end
      end
    end
  end

  task automatic sbits(input logic [7:0] tx, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi_i = tx[i];
      #100 spi_sck_i = 1'b1;
      #100 spi_sck_i = 1'b0;
    end
  endtask

  task automatic cs_hi();
    #100 spi_csn_i = 1'b1;
    spi_mosi_i = 1'b0;
    #300;
  endtask

  task automatic hdr(input logic [7:0] c, input logic [23:0] a);
    spi_csn_i = 1'b0;
    q_cmd.push_back(c);
    sbits(c, 8);
    sbits(a[23:16], 8);
    sbits(a[15:8], 8);
    sbits(a[7:0], 8);
  endtask

  task automatic wr2(input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1);
    hdr(8'h02, a);
    sbits(b0, 8);
    sbits(b1, 8);
    cs_hi();
  endtask

  task automatic rd(input logic [23:0] a, input int n, input logic [7:0] e0, input logic [7:0] e1);
    hdr(8'h03, a);
    q_rd.push_back(e0);
    if (n > 1) q_rd.push_back(e1);
    for (int i = 0; i < n; i++) sbits(8'h00, 8);
    cs_hi();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    #55;
    check("rst_miso", {31'h0, spi_miso_o}, 32'h0);
    check("rst_oe", {31'h0, spi_miso_oe_o}, 32'h0);
    check("rst_cmd_valid", {31'h0, cmd_valid_o}, 32'h0);
    check("rst_cmd", {24'h0, cmd_o}, 32'h0);
    check("rst_err", {31'h0, err_o}, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #200;

    // write/read
    wr2(24'h000010, 8'hA5, 8'h5A);
    rd(24'h000010, 2, 8'hA5, 8'h5A);
    check("pulses_t1", n_cmd_pulses, 32'd2);
    check("cmd_last_t1", {24'h0, cmd_o}, 32'h03);

    // address wrap
    wr2(24'h0000FF, 8'h11, 8'h22);
    rd(24'h0000FF, 2, 8'h11, 8'h22);
    rd(24'h000000, 1, 8'h22, 8'h00);

    // abort partial write
    wr2(24'h000020, 8'hC3, 8'h3C);
    hdr(8'h02, 24'h000020);
    sbits(8'hFF, 5);
    cs_hi();
    rd(24'h000020, 2, 8'hC3, 8'h3C);

    // async reset in the middle of a read
    hdr(8'h03, 24'h000010);
    sbits(8'h00, 4);
    #37 rst_ni = 1'b0;
    #1;
    check("arst_miso", {31'h0, spi_miso_o}, 32'h0);
    check("arst_oe", {31'h0, spi_miso_oe_o}, 32'h0);
    check("arst_cmd", {24'h0, cmd_o}, 32'h0);
    spi_csn_i = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b1;
    #300;
    rd(24'h000010, 2, 8'hA5, 8'h5A);
    check("err_clean", {31'h0, err_o}, 32'h0);

    // read-ID command
    oe_seen = 1'b0;
    spi_csn_i = 1'b0;
    q_cmd.push_back(8'h9F);
    sbits(8'h9F, 8);
`ifdef FPGA_SPIS_RDID_EN
    q_rd.push_back(8'hC2);
    q_rd.push_back(8'h20);
    q_rd.push_back(8'h17);
`endif
    for (int i = 0; i < 3; i++) sbits(8'h00, 8);
    cs_hi();
`ifdef FPGA_SPIS_RDID_EN
    check("rdid_oe", {31'h0, oe_seen}, 32'h1);
    check("rdid_err", {31'h0, err_o}, 32'h0);
`else
    check("rdid_oe", {31'h0, oe_seen}, 32'h0);
    check("rdid_err", {31'h0, err_o}, 32'h1);
`endif

    // unsupported command
    oe_seen = 1'b0;
    spi_csn_i = 1'b0;
    q_cmd.push_back(8'h77);
    sbits(8'h77, 8);
    sbits(8'h00, 8);
    cs_hi();
    check("bad_oe", {31'h0, oe_seen}, 32'h0);
    check("bad_err", {31'h0, err_o}, 32'h1);
    check("bad_cmd", {24'h0, cmd_o}, 32'h77);
    rd(24'h000010, 1, 8'hA5, 8'h00);
    check("err_sticky", {31'h0, err_o}, 32'h1);

    check("q_cmd_empty", q_cmd.size(), 32'd0);
    check("q_rd_empty", q_rd.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
